player_input_ctrl: RTL
======================

Name: player_input_ctrl

Overview:
- Sits directly upstream of Player, between the SoC keycode export and the Player movement inputs.
- Converts the raw 8-bit USB HID keycode into frame-aligned action signals:
  - move levels and a facing register,
  - a buffered jump request with ack handshake and a hold level,
  - cooldown-gated attack and dash pulses.
- Runs on the 50 MHz system clock and derives its frame tick from VGA_VS, so Player sees clean, single-frame-consistent commands.

Parameters:
- KEY_LEFT, 8'h04, HID code for move left (A)
- KEY_RIGHT, 8'h07, HID code for move right (D)
- KEY_JUMP, 8'h1A, HID code for jump (W)
- KEY_ATTACK, 8'h0D, HID code for attack (J)
- KEY_DASH, 8'h0E, HID code for dash (K)
- JUMP_BUF_FRAMES, 6, frames a jump press stays requested without ack (1..15)
- ATTACK_CD_FRAMES, 20, attack cooldown in frames (1..63)
- DASH_CD_FRAMES, 45, dash cooldown in frames (1..63)

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous, active-low reset
- keycode  in  8  current USB keycode from SoC; 8'h00 = no key
- frame_vs  in  1  VGA_VS, asynchronous to logic, active low
- jump_ack  in  1  1-Clk pulse from Player: jump consumed
- frame_tick  out  1  1-Clk pulse per frame
- move_left  out  1  left held this frame
- move_right  out  1  right held this frame
- facing_left  out  1  last horizontal direction pressed; 0 = right
- jump_req  out  1  buffered jump request level
- jump_hold  out  1  jump key still held after an acked jump
- attack_pulse  out  1  1-Clk attack trigger
- dash_pulse  out  1  1-Clk dash trigger

Behaviour:
- Reset: every output and internal register is 0 (facing right). Asynchronous assert; takes effect mid-operation.
- frame_vs path:
  - double-flopped, then rising-edge detected.
  - frame_tick fires 3 Clk after the frame_vs rise (2 sync flops plus 1 edge register), aligned with Player's frame_clk posedge.
- On frame_tick:
  - key_q <= keycode; key_p <= key_q.
  - All action logic evaluates key_q/key_p in the cycle after frame_tick (T+1). Outputs are registered and update at T+2.
- Press edge of key K: key_q==K && key_p!=K. A single keycode means only one action key is active at a time.
- Move and facing:
  - move_left = (key_q==KEY_LEFT); move_right = (key_q==KEY_RIGHT).
  - facing_left set by a LEFT press edge, cleared by a RIGHT press edge, otherwise held.
- Jump FSM, states IDLE / BUFFERED / HELD:
  - IDLE: on a JUMP press edge -> BUFFERED, jump_req=1, buf_cnt=JUMP_BUF_FRAMES.
  - BUFFERED, jump_ack seen (any Clk):
    - jump_req=0 on the next Clk.
    - -> HELD if key_q==KEY_JUMP, else -> IDLE.
  - BUFFERED, per tick: buf_cnt decrements; when it reaches 0, jump_req=0 and -> IDLE.
  - BUFFERED, ack and expiry in the same cycle: ack wins (-> HELD/IDLE by key).
  - HELD: jump_hold=1. On a tick with key_q!=KEY_JUMP -> IDLE, jump_hold=0.
  - jump_ack in IDLE or HELD is ignored.
- Attack:
  - ATTACK press edge with atk_cd==0 -> attack_pulse for exactly 1 Clk, atk_cd=ATTACK_CD_FRAMES.
  - atk_cd decrements once per tick, saturating at 0.
  - Press while atk_cd>0 is dropped, not queued. Holding the key never retriggers; a re-press is required.
- Dash: identical mechanism with dash_cd / DASH_CD_FRAMES / dash_pulse.
- Counter width: 6 bits, no wrap.
- Missing frame_vs (no ticks): all state frozen; pulses never fire.

Optional Feature:
- Macro: PLAYER_INPUT_DASH_EN
- Defined: dash logic as above.
- Undefined: dash_pulse tied 0, dash_cd register and KEY_DASH compare removed; port list unchanged.

Test Plan:
- Reset_n low mid-BUFFERED with atk_cd=10 -> all outputs 0 immediately; after release, ATTACK press edge fires attack_pulse on its first tick.
- Toggle frame_vs low->high -> frame_tick is exactly 1 Clk wide, 3 Clk after the rise; keycode changes between ticks are not visible on move_left/move_right.
- Jump buffering:
  - keycode=8'h1A for 10 ticks, jump_ack at tick 2 -> jump_req high from tick 0+2 Clk until 1 Clk after ack; jump_hold=1 until the first tick with keycode!=8'h1A.
  - Same with no ack -> jump_req drops after exactly 6 ticks.
  - Ack on the expiry cycle -> HELD.
- Attack cooldown: press J, release, re-press at tick 5 and at tick 21 -> one pulse at tick 0, none at 5, second at 21 (cd=20). J held for 50 ticks -> exactly 1 pulse.
- Move and facing: keycode 04 -> 00 -> 07 -> 00 -> move_left 1/0/0/0, move_right 0/0/1/0, facing_left 1/1/0/0.
- Dash, with PLAYER_INPUT_DASH_EN: press K twice 10 ticks apart -> 1 dash_pulse. Without the macro: dash_pulse stays 0 for any keycode.

Source files
------------

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: turns the raw USB HID keycode into frame-aligned
// movement, jump, attack and dash commands for the Player block.
// The frame tick is recovered from the asynchronous VGA_VS input.
// Optional dash logic is compiled in when PLAYER_INPUT_DASH_EN is defined;
// without it dash_pulse is held at 0 and the port list is unchanged.
module player_input_ctrl #(
  parameter logic [7:0] KEY_LEFT         = 8'h04,
  parameter logic [7:0] KEY_RIGHT        = 8'h07,
  parameter logic [7:0] KEY_JUMP         = 8'h1A,
  parameter logic [7:0] KEY_ATTACK       = 8'h0D,
  parameter int         JUMP_BUF_FRAMES  = 6,
  parameter int         ATTACK_CD_FRAMES = 20
`ifdef PLAYER_INPUT_DASH_EN
  ,
  parameter logic [7:0] KEY_DASH         = 8'h0E,
  parameter int         DASH_CD_FRAMES   = 45
`endif
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_vs,
  input  logic       jump_ack,
  output logic       frame_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       facing_left,
  output logic       jump_req,
  output logic       jump_hold,
  output logic       attack_pulse,
  output logic       dash_pulse
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    J_IDLE     = 2'd0,
    J_BUFFERED = 2'd1,
    J_HELD     = 2'd2
  } jump_state_t;

  // Cooldown counters saturate at zero rather than wrapping.
  function automatic logic [CNT_W-1:0] cd_dec(input logic [CNT_W-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - 1'b1;
  endfunction

  logic             vs_p0, vs_p1, vs_p2;
  logic             eval_p1;
  logic [7:0]       key_q, key_p;
  jump_state_t      jump_state;
  logic [CNT_W-1:0] buf_cnt;
  logic [CNT_W-1:0] atk_cd;
  logic             left_edge, right_edge, jump_edge, atk_edge;

  // A key is "pressed" only in the frame it first appears.
  assign left_edge  = (key_q == KEY_LEFT)   && (key_p != KEY_LEFT);
  assign right_edge = (key_q == KEY_RIGHT)  && (key_p != KEY_RIGHT);
  assign jump_edge  = (key_q == KEY_JUMP)   && (key_p != KEY_JUMP);
  assign atk_edge   = (key_q == KEY_ATTACK) && (key_p != KEY_ATTACK);

  // Stage p0-p2: two-flop synchroniser on VS, then a registered rising-edge detect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_p0      <= 1'b0;
      vs_p1      <= 1'b0;
      vs_p2      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_p0      <= frame_vs;
      vs_p1      <= vs_p0;
      vs_p2      <= vs_p1;
      frame_tick <= vs_p1 & ~vs_p2;
    end
  end

  // Stage p1: sample the keycode once per frame and flag the evaluation cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q   <= '0;
      key_p   <= '0;
      eval_p1 <= 1'b0;
    end else begin
      eval_p1 <= frame_tick;
      if (frame_tick) begin
        key_q <= keycode;
        key_p <= key_q;
      end
    end
  end

  // Move levels follow the sampled key; facing remembers the last direction pressed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      facing_left <= 1'b0;
    end else if (eval_p1) begin
      move_left  <= (key_q == KEY_LEFT);
      move_right <= (key_q == KEY_RIGHT);
      if (left_edge) begin
        facing_left <= 1'b1;
      end else if (right_edge) begin
        facing_left <= 1'b0;
      end
    end
  end

  // Jump FSM: a press is buffered for a few frames until Player acks it;
  // an ack always beats a same-cycle expiry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      jump_state <= J_IDLE;
      jump_req   <= 1'b0;
      jump_hold  <= 1'b0;
      buf_cnt    <= '0;
    end else begin
      case (jump_state)
        J_IDLE: begin
          if (eval_p1 && jump_edge) begin
            jump_state <= J_BUFFERED;
            jump_req   <= 1'b1;
            buf_cnt    <= CNT_W'(JUMP_BUF_FRAMES);
          end
        end
        J_BUFFERED: begin
          if (jump_ack) begin
            jump_req <= 1'b0;
            buf_cnt  <= '0;
            if (key_q == KEY_JUMP) begin
              jump_state <= J_HELD;
              jump_hold  <= 1'b1;
            end else begin
              jump_state <= J_IDLE;
            end
          end else if (eval_p1) begin
            buf_cnt <= cd_dec(buf_cnt);
            if (buf_cnt <= CNT_W'(1)) begin
              jump_req   <= 1'b0;
              jump_state <= J_IDLE;
            end
          end
        end
        J_HELD: begin
          if (eval_p1 && (key_q != KEY_JUMP)) begin
            jump_state <= J_IDLE;
            jump_hold  <= 1'b0;
          end
        end
        default: begin
          jump_state <= J_IDLE;
          jump_req   <= 1'b0;
          jump_hold  <= 1'b0;
          buf_cnt    <= '0;
        end
      endcase
    end
  end

  // Attack: fresh press with cooldown expired fires a one-cycle pulse; others are dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      attack_pulse <= 1'b0;
      atk_cd       <= '0;
    end else begin
      attack_pulse <= 1'b0;
      if (eval_p1) begin
        if (atk_edge && (atk_cd == '0)) begin
          attack_pulse <= 1'b1;
          atk_cd       <= CNT_W'(ATTACK_CD_FRAMES);
        end else begin
          atk_cd <= cd_dec(atk_cd);
        end
      end
    end
  end

`ifdef PLAYER_INPUT_DASH_EN
  logic [CNT_W-1:0] dash_cd;
  logic             dash_edge;

  assign dash_edge = (key_q == KEY_DASH) && (key_p != KEY_DASH);

  // Dash: same press-and-cooldown gating as attack, with its own counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dash_pulse <= 1'b0;
      dash_cd    <= '0;
    end else begin
      dash_pulse <= 1'b0;
      if (eval_p1) begin
        if (dash_edge && (dash_cd == '0)) begin
          dash_pulse <= 1'b1;
          dash_cd    <= CNT_W'(DASH_CD_FRAMES);
        end else begin
          dash_cd <= cd_dec(dash_cd);
        end
      end
    end
  end
`else
  assign dash_pulse = 1'b0;
`endif

endmodule
